// File: rtl/counter_sched_if.sv
// Request/grant bundle between the requesters and the shared-counter scheduler.
interface counter_sched_if #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned WIDTH = 8,
  parameter int unsigned IDW   = 2
) ();

  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] len;
  logic [NREQ-1:0]       gnt;
  logic                  busy;
  logic [WIDTH-1:0]      value;
  logic                  done;
  logic [IDW-1:0]        done_id;

  // Requester side
  modport master (
    output req, len,
    input  gnt, busy, value, done, done_id
  );

  // Scheduler side
  modport slave (
    input  req, len,
    output gnt, busy, value, done, done_id
  );

endinterface

// File: rtl/counter_sched.sv
// Round-robin scheduler time-sharing one interval counter among NREQ requesters.
// A granted requester gets a run of len cycles (len=0 behaves as len=1), ending
// in a one-cycle done pulse tagged with its index. Dropping req mid-run aborts.
module counter_sched #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned WIDTH = 8,
  parameter int unsigned IDW   = 2
) (
  input logic             clk,
  input logic             reset,
  counter_sched_if.slave  bus
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [NREQ-1:0]  gnt_q, gnt_d;
  logic [WIDTH-1:0] value_q, value_d;
  logic [WIDTH-1:0] len_q, len_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [IDW-1:0]   win_q, win_d;
  logic             done_q, done_d;
  logic [IDW-1:0]   done_id_q, done_id_d;

  logic             found;
  logic [IDW-1:0]   winner;
  logic [IDW-1:0]   arb_idx;
  logic             terminal;
  logic [WIDTH-1:0] len_arr [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_len
    assign len_arr[g] = bus.len[g*WIDTH +: WIDTH];
  end

  // Circular priority search starting at ptr; scanning downward lets the
  // lowest offset from ptr be the last (winning) assignment.
  always_comb begin
    found   = 1'b0;
    winner  = '0;
    arb_idx = '0;
    for (int i = int'(NREQ) - 1; i >= 0; i--) begin
      arb_idx = IDW'((int'(ptr_q) + i) % NREQ);
      if (bus.req[arb_idx]) begin
        found  = 1'b1;
        winner = arb_idx;
      end
    end
  end

  // Run ends on the cycle whose successor would reach len_q; len_q=0 is a one-cycle run.
  assign terminal = (len_q == '0) || ((value_q + WIDTH'(1)) == len_q);

  // Next-state and registered-output logic.
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    value_d   = value_q;
    len_d     = len_q;
    ptr_d     = ptr_q;
    win_d     = win_q;
    done_d    = 1'b0;
    done_id_d = done_id_q;
    unique case (state_q)
      StIdle: begin
        value_d = '0;
        gnt_d   = '0;
        if (found) begin
          state_d = StRun;
          gnt_d   = NREQ'(1) << winner;
          len_d   = len_arr[winner];
          ptr_d   = IDW'((int'(winner) + 1) % NREQ);
          win_d   = winner;
        end
      end
      StRun: begin
        if (!bus.req[win_q]) begin
          // Abort beats terminal: no done pulse.
          state_d = StIdle;
          gnt_d   = '0;
          value_d = '0;
        end else if (terminal) begin
          state_d   = StDone;
          gnt_d     = '0;
          done_d    = 1'b1;
          done_id_d = win_q;
        end else begin
          value_d = value_q + WIDTH'(1);
        end
      end
      StDone: begin
        state_d = StIdle;
        value_d = '0;
      end
      default: begin
        state_d = StIdle;
        gnt_d   = '0;
        value_d = '0;
      end
    endcase
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= StIdle;
      gnt_q     <= '0;
      value_q   <= '0;
      len_q     <= '0;
      ptr_q     <= '0;
      win_q     <= '0;
      done_q    <= 1'b0;
      done_id_q <= '0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      value_q   <= value_d;
      len_q     <= len_d;
      ptr_q     <= ptr_d;
      win_q     <= win_d;
      done_q    <= done_d;
      done_id_q <= done_id_d;
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.busy    = (state_q != StIdle);
  assign bus.value   = value_q;
  assign bus.done    = done_q;
  assign bus.done_id = done_id_q;

endmodule

// File: tb/tb_counter_sched.sv
// Directed bench for counter_sched: reset, single run, round-robin, abort,
// reset mid-run and length boundaries, with hand-computed expectations.
module tb_counter_sched;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  counter_sched_if #(.NREQ(4), .WIDTH(8), .IDW(2)) bus ();

  counter_sched #(.NREQ(4), .WIDTH(8), .IDW(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packed observation: {gnt[15:12], busy[11], value[10:3], done[2], done_id[1:0]}
  logic [15:0] obs;
  assign obs = {bus.gnt, bus.busy, bus.value, bus.done, bus.done_id};

  function automatic logic [15:0] pk(input logic [3:0] g, input logic b, input logic [7:0] v,
                                     input logic d, input logic [1:0] id);
    pk = {g, b, v, d, id};
  endfunction

  // done_id is only meaningful while done is expected high.
  function automatic logic [15:0] msk(input logic [15:0] v, input logic d);
    msk = d ? v : {v[15:2], 2'b00};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset   = 1'b0;
    bus.req = '0;
    step();
    step();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    logic [15:0] e;
    reset   = 1'b0;
    bus.req = 4'b1111;
    bus.len = {8'd5, 8'd5, 8'd5, 8'd5};
    for (int c = 0; c < 3; c++) begin
      step();
      e = pk(4'b0000, 1'b0, 8'd0, 1'b0, 2'd0);
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL reset cyc%0d: got %h exp %h", c, obs, e);
      end
    end
    reset = 1'b1;
    step();
    e = pk(4'b0001, 1'b1, 8'd0, 1'b0, 2'd0);
    checks++;
    if (msk(obs, e[2]) !== msk(e, e[2])) begin
      errors++;
      $display("FAIL reset first_grant: got %h exp %h", obs, e);
    end
    bus.req = '0;
    step();
    e = pk(4'b0000, 1'b0, 8'd0, 1'b0, 2'd0);
    checks++;
    if (msk(obs, e[2]) !== msk(e, e[2])) begin
      errors++;
      $display("FAIL reset drop_abort: got %h exp %h", obs, e);
    end
  endtask

  task automatic test_single();
    logic [15:0] e;
    do_reset();
    bus.len = {8'd9, 8'd9, 8'd9, 8'd5};
    bus.req = 4'b0001;
    for (int j = 0; j < 5; j++) begin
      step();
      if (j == 0) bus.len[7:0] = 8'd2;  // must be ignored after grant
      e = pk(4'b0001, 1'b1, 8'(j), 1'b0, 2'd0);
      checks++;
      if (msk(obs, e[2]) !== msk(e, e[2])) begin
        errors++;
        $display("FAIL single run v%0d: got %h exp %h", j, obs, e);
      end
    end
    step();
    e = pk(4'b0000, 1'b1, 8'd4, 1'b1, 2'd0);
    checks++;
    if (obs !== e) begin
      errors++;
      $display("FAIL single done: got %h exp %h", obs, e);
    end
    bus.req = '0;
    step();
    e = pk(4'b0000, 1'b0, 8'd0, 1'b0, 2'd0);
    checks++;
    if (msk(obs, e[2]) !== msk(e, e[2])) begin
      errors++;
      $display("FAIL single idle: got %h exp %h", obs, e);
    end
  endtask

  task automatic test_round_robin();
    logic [15:0] e;
    logic [1:0]  id;
    logic [3:0]  oh;
    int          ph;
    do_reset();
    bus.len = {8'd0, 8'd3, 8'd0, 8'd3};
    bus.req = 4'b0101;
    // Period 5: three RUN cycles, DONE, IDLE; owners alternate 0,2,0,2.
    for (int c = 1; c <= 20; c++) begin
      step();
      ph = (c - 1) % 5;
      id = (((c - 1) / 5) % 2 == 1) ? 2'd2 : 2'd0;
      oh = 4'b0001 << id;
      if (ph < 3)       e = pk(oh, 1'b1, 8'(ph), 1'b0, 2'd0);
      else if (ph == 3) e = pk(4'b0000, 1'b1, 8'd2, 1'b1, id);
      else              e = pk(4'b0000, 1'b0, 8'd0, 1'b0, 2'd0);
      checks++;
      if (msk(obs, e[2]) !== msk(e, e[2])) begin
        errors++;
        $display("FAIL round_robin cyc%0d: got %h exp %h", c, obs, e);
      end
    end
    bus.req = '0;
    step();
  endtask

  task automatic test_abort();
    logic [15:0] e;
    do_reset();
    bus.len = {8'd2, 8'd0, 8'd10, 8'd0};
    bus.req = 4'b1010;
    for (int j = 0; j <= 4; j++) begin
      step();
      e = pk(4'b0010, 1'b1, 8'(j), 1'b0, 2'd0);
      checks++;
      if (msk(obs, e[2]) !== msk(e, e[2])) begin
        errors++;
        $display("FAIL abort run v%0d: got %h exp %h", j, obs, e);
      end
    end
    bus.req = 4'b1000;
    step();
    e = pk(4'b0000, 1'b0, 8'd0, 1'b0, 2'd0);
    checks++;
    if (msk(obs, e[2]) !== msk(e, e[2])) begin
      errors++;
      $display("FAIL abort idle: got %h exp %h", obs, e);
    end
    step();
    e = pk(4'b1000, 1'b1, 8'd0, 1'b0, 2'd0);
    checks++;
    if (msk(obs, e[2]) !== msk(e, e[2])) begin
      errors++;
      $display("FAIL abort next_grant: got %h exp %h", obs, e);
    end
    step();
    step();
    e = pk(4'b0000, 1'b1, 8'd1, 1'b1, 2'd3);
    checks++;
    if (obs !== e) begin
      errors++;
      $display("FAIL abort req3_done: got %h exp %h", obs, e);
    end
    bus.req = '0;
    step();
  endtask

  // Runs straight after test_abort: done_id=3 and ptr=0 beforehand.
  task automatic test_reset_mid_run();
    logic [15:0] e;
    bus.len = {8'd0, 8'd0, 8'd20, 8'd0};
    bus.req = 4'b0010;
    for (int j = 0; j <= 7; j++) step();
    e = pk(4'b0010, 1'b1, 8'd7, 1'b0, 2'd0);
    checks++;
    if (msk(obs, e[2]) !== msk(e, e[2])) begin
      errors++;
      $display("FAIL midreset before: got %h exp %h", obs, e);
    end
    reset = 1'b0;
    step();
    e = pk(4'b0000, 1'b0, 8'd0, 1'b0, 2'd0);
    checks++;
    if (obs !== e) begin
      errors++;
      $display("FAIL midreset outputs: got %h exp %h", obs, e);
    end
    // ptr=0 picks requester 1; a stale ptr of 2 would pick requester 2.
    reset   = 1'b1;
    bus.req = 4'b0110;
    step();
    e = pk(4'b0010, 1'b1, 8'd0, 1'b0, 2'd0);
    checks++;
    if (msk(obs, e[2]) !== msk(e, e[2])) begin
      errors++;
      $display("FAIL midreset ptr: got %h exp %h", obs, e);
    end
    bus.req = '0;
    step();
  endtask

  task automatic test_boundaries();
    logic [15:0] e;
    do_reset();
    bus.len = '0;
    bus.req = 4'b0001;
    step();
    e = pk(4'b0001, 1'b1, 8'd0, 1'b0, 2'd0);
    checks++;
    if (msk(obs, e[2]) !== msk(e, e[2])) begin
      errors++;
      $display("FAIL len0 run: got %h exp %h", obs, e);
    end
    step();
    e = pk(4'b0000, 1'b1, 8'd0, 1'b1, 2'd0);
    checks++;
    if (obs !== e) begin
      errors++;
      $display("FAIL len0 done: got %h exp %h", obs, e);
    end
    bus.req = '0;
    step();
    do_reset();
    bus.len = {8'd0, 8'd0, 8'd0, 8'd255};
    bus.req = 4'b0001;
    for (int j = 0; j <= 254; j++) begin
      step();
      e = pk(4'b0001, 1'b1, 8'(j), 1'b0, 2'd0);
      checks++;
      if (msk(obs, e[2]) !== msk(e, e[2])) begin
        errors++;
        $display("FAIL len255 v%0d: got %h exp %h", j, obs, e);
      end
    end
    step();
    e = pk(4'b0000, 1'b1, 8'd254, 1'b1, 2'd0);
    checks++;
    if (obs !== e) begin
      errors++;
      $display("FAIL len255 done: got %h exp %h", obs, e);
    end
    bus.req = '0;
    step();
    e = pk(4'b0000, 1'b0, 8'd0, 1'b0, 2'd0);
    checks++;
    if (msk(obs, e[2]) !== msk(e, e[2])) begin
      errors++;
      $display("FAIL len255 idle: got %h exp %h", obs, e);
    end
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    reset   = 1'b0;
    bus.req = '0;
    bus.len = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_abort();
    test_reset_mid_run();
    test_boundaries();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
